// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - bit-serial adder/subtractor with start/busy/done handshake
// One full-adder stage plus a carry flop processes one operand bit per clock, LSB first.
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Co,
  output logic             Ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sum_bit;
  logic             last_bit;

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    f_d      = f_q;
    carry_d  = carry_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    sum_bit  = opa_q[0] ^ opb_q[0] ^ carry_q;
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + ~borrow, so the adder itself never changes.
          opa_d   = A;
          opb_d   = Sub ? ~B : B;
          carry_d = Sub ? ~Cin : Cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = sum_bit;
        opa_d            = opa_q >> 1;
        opb_d            = opb_q >> 1;
        cnt_d            = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // On the last bit, opa_q[0]/opb_q[0] hold the operand MSBs.
          state_d = DONE;
          f_d     = res_d;
          co_d    = carry_d;
          ovf_d   = (opa_q[0] & opb_q[0] & ~sum_bit) | (~opa_q[0] & ~opb_q[0] & sum_bit);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      f_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      f_q     <= f_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign F    = f_q;
  assign Co   = co_q;
  assign Ovf  = ovf_q;

endmodule
